npu_dot_mac: RTL and testbench

Parametrised, pipelined signed dot-product multiply-accumulate unit for the NPU datapath. It generalises the two-lane multiply-add primitive to LANES products per beat. It accumulates across multi-beat vectors, then rounds, shifts and saturates the result. Valid/ready handshakes on both sides let it sit between the operand fetch stream and the activation/writeback stage.

---
 rtl/npu_dot_mac.sv | 179 +++++++++++++++++
 tb/tb_npu_dot_mac.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_dot_mac.sv
// Pipelined signed dot-product MAC: LANES products per beat, multi-beat accumulation,
// then round-half-up, arithmetic right shift and saturation to OUT_W bits.
module npu_dot_mac #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [SHIFT_W-1:0]      in_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] ONE     = {{ACC_W{1'b0}}, 1'b1};

  logic stall;

  logic                     p_valid_q, p_valid_d;
  logic                     p_first_q, p_first_d;
  logic                     p_last_q,  p_last_d;
  logic [SHIFT_W-1:0]       p_shift_q, p_shift_d;
  logic signed [PROD_W-1:0] p_prod_q [LANES];
  logic signed [PROD_W-1:0] p_prod_d [LANES];

  logic                     s_valid_q, s_valid_d;
  logic                     s_first_q, s_first_d;
  logic                     s_last_q,  s_last_d;
  logic [SHIFT_W-1:0]       s_shift_q, s_shift_d;
  logic signed [ACC_W-1:0]  s_sum_q,   s_sum_d;

  logic [ACC_W-1:0]         acc_q,       acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q,  out_data_d;
  logic                     out_sat_q,   out_sat_d;

  logic [ACC_W-1:0]         next_acc;
  logic signed [ACC_W:0]    ext_acc;
  logic signed [ACC_W:0]    bias;
  logic signed [ACC_W:0]    rounded;
  logic [OUT_W-1:0]         clamped;
  logic                     clamp_hit;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  // A held result with no consumer freezes the whole pipeline, like ce=0.
  always_comb begin
    stall    = !ce || (out_valid_q && !out_ready);
    in_ready = !reset && !stall;
  end

  always_comb begin
    p_valid_d = p_valid_q;
    p_first_d = p_first_q;
    p_last_d  = p_last_q;
    p_shift_d = p_shift_q;
    p_prod_d  = p_prod_q;
    a_ext     = '0;
    b_ext     = '0;
    if (!stall) begin
      p_valid_d = in_valid && in_ready;
      p_first_d = in_first;
      p_last_d  = in_last;
      p_shift_d = in_shift;
      for (int i = 0; i < LANES; i++) begin
        a_ext       = PROD_W'($signed(in_a[i*DATA_W +: DATA_W]));
        b_ext       = PROD_W'($signed(in_b[i*DATA_W +: DATA_W]));
        p_prod_d[i] = a_ext * b_ext;
      end
    end
  end

  always_comb begin
    s_valid_d = s_valid_q;
    s_first_d = s_first_q;
    s_last_d  = s_last_q;
    s_shift_d = s_shift_q;
    s_sum_d   = s_sum_q;
    if (!stall) begin
      s_valid_d = p_valid_q;
      s_first_d = p_first_q;
      s_last_d  = p_last_q;
      s_shift_d = p_shift_q;
      s_sum_d   = '0;
      for (int i = 0; i < LANES; i++) begin
        s_sum_d = s_sum_d + ACC_W'(p_prod_q[i]);
      end
    end
  end

  // One extra bit of headroom keeps the rounding bias from overflowing.
  always_comb begin
    next_acc  = (s_first_q ? '0 : acc_q) + s_sum_q;
    ext_acc   = {next_acc[ACC_W-1], next_acc};
    bias      = (s_shift_q == '0) ? '0 : (ONE << (s_shift_q - SHIFT_W'(1)));
    rounded   = (ext_acc + bias) >>> s_shift_q;
    clamped   = rounded[OUT_W-1:0];
    clamp_hit = 1'b0;
    if (rounded > SAT_MAX) begin
      clamped   = SAT_MAX[OUT_W-1:0];
      clamp_hit = 1'b1;
    end else if (rounded < SAT_MIN) begin
      clamped   = SAT_MIN[OUT_W-1:0];
      clamp_hit = 1'b1;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (!stall) begin
      out_valid_d = s_valid_q && s_last_q;
      if (s_valid_q) begin
        acc_d = s_last_q ? '0 : next_acc;
      end
      if (s_valid_q && s_last_q) begin
        out_data_d = clamped;
        out_sat_d  = clamp_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_shift_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        p_prod_q[i] <= '0;
      end
      s_valid_q   <= 1'b0;
      s_first_q   <= 1'b0;
      s_last_q    <= 1'b0;
      s_shift_q   <= '0;
      s_sum_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      p_shift_q   <= p_shift_d;
      p_prod_q    <= p_prod_d;
      s_valid_q   <= s_valid_d;
      s_first_q   <= s_first_d;
      s_last_q    <= s_last_d;
      s_shift_q   <= s_shift_d;
      s_sum_q     <= s_sum_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_npu_dot_mac.sv
// Directed bench for npu_dot_mac: hand-computed dot products, rounding, saturation,
// backpressure, clock-enable freeze and mid-vector reset.
module tb_npu_dot_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_first;
  logic        in_last;
  logic [4:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

  npu_dot_mac #(
    .DATA_W(8), .LANES(4), .ACC_W(32), .OUT_W(16), .SHIFT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(v0);
    b1 = 8'(v1);
    b2 = 8'(v2);
    b3 = 8'(v3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic first, input logic last, input logic [4:0] sh);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    in_shift = sh;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obsv,
                             input logic signed [31:0] expv);
    total++;
    assert (obsv === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obsv, expv);
    end
  endtask

  task automatic singleVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input int expData, input logic expSat);
    applyStimulus(a, b, 1'b1, 1'b1, sh);
    tick();
    idle();
    tick();
    checkOutput({tag, "_early"}, {31'b0, out_valid}, 0);
    tick();
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 1);
    checkOutput({tag, "_data"}, $signed(out_data), expData);
    checkOutput({tag, "_sat"}, {31'b0, out_sat}, {31'b0, expSat});
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    ce        = 1'b1;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_shift  = '0;
    idle();

    // Reset state
    tick();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_out_data", $signed(out_data), 0);
    checkOutput("rst_out_sat", {31'b0, out_sat}, 0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 1);

    // Single-beat vector with explicit latency check
    applyStimulus(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1, 5'd0);
    #1;
    checkOutput("single_in_ready", {31'b0, in_ready}, 1);
    tick();
    idle();
    checkOutput("single_lat1", {31'b0, out_valid}, 0);
    tick();
    checkOutput("single_lat2", {31'b0, out_valid}, 0);
    tick();
    checkOutput("single_valid", {31'b0, out_valid}, 1);
    checkOutput("single_data", $signed(out_data), 70);
    checkOutput("single_sat", {31'b0, out_sat}, 0);
    tick();
    checkOutput("single_clear", {31'b0, out_valid}, 0);

    // Multi-beat accumulate followed by an un-flagged beat that starts from zero
    applyStimulus(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0, 1'b1, 5'd0);
    tick();
    applyStimulus(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, 1'b1, 5'd0);
    tick();
    idle();
    checkOutput("multi_no_partial", {31'b0, out_valid}, 0);
    tick();
    checkOutput("multi_valid", {31'b0, out_valid}, 1);
    checkOutput("multi_data", $signed(out_data), 24);
    tick();
    checkOutput("autoclr_valid", {31'b0, out_valid}, 1);
    checkOutput("autoclr_data", $signed(out_data), 4);
    tick();
    checkOutput("autoclr_done", {31'b0, out_valid}, 0);

    // Saturation and sign
    singleVector("sat_pos", pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 5'd0, 32767, 1'b1);
    singleVector("sat_shift2", pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 5'd2, 16384, 1'b0);
    singleVector("sat_neg", pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 5'd0, -32768, 1'b1);

    // Rounding (round half up)
    singleVector("rnd_70", pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 5'd2, 18, 1'b0);
    singleVector("rnd_m70", pack4(-1, -2, -3, -4), pack4(5, 6, 7, 8), 5'd2, -17, 1'b0);
    singleVector("rnd_6", pack4(1, 2, 0, 0), pack4(2, 2, 0, 0), 5'd2, 2, 1'b0);
    singleVector("rnd_5", pack4(5, 0, 0, 0), pack4(1, 0, 0, 0), 5'd1, 3, 1'b0);

    // Backpressure: five single-beat vectors, consumer stalls at the first result
    out_ready = 1'b0;
    applyStimulus(pack4(1, 0, 0, 0), pack4(10, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    #1;
    checkOutput("bp_accept1", {31'b0, in_ready}, 1);
    tick();
    applyStimulus(pack4(2, 0, 0, 0), pack4(10, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    tick();
    applyStimulus(pack4(3, 0, 0, 0), pack4(10, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    tick();
    applyStimulus(pack4(4, 0, 0, 0), pack4(10, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    #1;
    checkOutput("bp_first_valid", {31'b0, out_valid}, 1);
    checkOutput("bp_first_data", $signed(out_data), 10);
    checkOutput("bp_in_ready_low", {31'b0, in_ready}, 0);
    tick();
    #1;
    checkOutput("bp_hold_ready", {31'b0, in_ready}, 0);
    checkOutput("bp_hold_data", $signed(out_data), 10);
    tick();
    checkOutput("bp_hold_valid", {31'b0, out_valid}, 1);
    checkOutput("bp_hold_data2", $signed(out_data), 10);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, in_ready}, 1);
    tick();
    checkOutput("bp_r2", $signed(out_data), 20);
    checkOutput("bp_r2_valid", {31'b0, out_valid}, 1);
    applyStimulus(pack4(5, 0, 0, 0), pack4(10, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    tick();
    idle();
    checkOutput("bp_r3", $signed(out_data), 30);
    checkOutput("bp_r3_valid", {31'b0, out_valid}, 1);
    tick();
    checkOutput("bp_r4", $signed(out_data), 40);
    checkOutput("bp_r4_valid", {31'b0, out_valid}, 1);
    tick();
    checkOutput("bp_r5", $signed(out_data), 50);
    checkOutput("bp_r5_valid", {31'b0, out_valid}, 1);
    tick();
    checkOutput("bp_drained", {31'b0, out_valid}, 0);

    // Clock-enable freeze of two cycles shifts everything by two
    applyStimulus(pack4(7, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    tick();
    ce = 1'b0;
    applyStimulus(pack4(8, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    #1;
    checkOutput("ce_in_ready_low", {31'b0, in_ready}, 0);
    tick();
    tick();
    ce = 1'b1;
    #1;
    checkOutput("ce_in_ready_back", {31'b0, in_ready}, 1);
    checkOutput("ce_not_yet", {31'b0, out_valid}, 0);
    tick();
    idle();
    checkOutput("ce_not_yet2", {31'b0, out_valid}, 0);
    tick();
    checkOutput("ce_r1_valid", {31'b0, out_valid}, 1);
    checkOutput("ce_r1_data", $signed(out_data), 7);
    tick();
    checkOutput("ce_r2_valid", {31'b0, out_valid}, 1);
    checkOutput("ce_r2_data", $signed(out_data), 8);
    tick();
    checkOutput("ce_done", {31'b0, out_valid}, 0);

    // Reset in the middle of a vector discards it
    applyStimulus(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, 1'b0, 5'd0);
    tick();
    idle();
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 0);
    tick();
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 0);
    checkOutput("mid_rst_data", $signed(out_data), 0);
    checkOutput("mid_rst_sat", {31'b0, out_sat}, 0);
    reset = 1'b0;
    applyStimulus(pack4(1, 0, 0, 0), pack4(9, 0, 0, 0), 1'b1, 1'b1, 5'd0);
    #1;
    checkOutput("mid_rst_accept", {31'b0, in_ready}, 1);
    tick();
    idle();
    checkOutput("mid_rst_q1", {31'b0, out_valid}, 0);
    tick();
    checkOutput("mid_rst_q2", {31'b0, out_valid}, 0);
    tick();
    checkOutput("mid_rst_r_valid", {31'b0, out_valid}, 1);
    checkOutput("mid_rst_r_data", $signed(out_data), 9);
    tick();
    checkOutput("mid_rst_end", {31'b0, out_valid}, 0);
    tick();
    checkOutput("mid_rst_end2", {31'b0, out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
